// File: rtl/hsv_core_commit_ctrl.sv
// Commit-stage controller: retires in-order beats, turns trap/mret/redirect/wfi into ctrl_* events
// and answers the global flush handshake. Optional token matching: define HSV_COMMIT_TOKEN_CHECK_EN.
module hsv_core_commit_ctrl #(
  parameter int TOKEN_W = 3
) (
  input  logic               clk_core,
  input  logic               rst_core_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOKEN_W-1:0] in_token,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_next_pc,
  input  logic               in_trap,
  input  logic [4:0]         in_trap_cause,
  input  logic [31:0]        in_trap_value,
  input  logic               in_mode_return,
  input  logic               in_redirect,
  input  logic               in_wfi,
  output logic [TOKEN_W-1:0] commit_token,
  output logic               ctrl_flush_begin,
  output logic               ctrl_trap,
  output logic [4:0]         ctrl_trap_cause,
  output logic [31:0]        ctrl_trap_value,
  output logic               ctrl_mode_return,
  output logic [31:0]        ctrl_next_pc,
  output logic               ctrl_commit,
  input  logic               ctrl_wait_irq,
  input  logic               ctrl_begin_irq,
  input  logic               flush_req,
  output logic               flush_ack_commit
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t state;
  logic   beat_fire;
  logic   beat_match;

  assign beat_fire = in_valid && in_ready;

`ifdef HSV_COMMIT_TOKEN_CHECK_EN
  assign beat_match = (in_token == commit_token);
  logic unused_inputs;
  assign unused_inputs = ctrl_wait_irq;
`else
  // Without token checking every accepted beat is trusted to be the next in order.
  assign beat_match = 1'b1;
  logic unused_inputs;
  assign unused_inputs = ^{ctrl_wait_irq, in_token};
`endif

  always_ff @(posedge clk_core) begin
    if (!rst_core_n) begin
      state            <= S_RUN;
      in_ready         <= 1'b1;
      commit_token     <= '0;
      ctrl_flush_begin <= 1'b0;
      ctrl_trap        <= 1'b0;
      ctrl_trap_cause  <= '0;
      ctrl_trap_value  <= '0;
      ctrl_mode_return <= 1'b0;
      ctrl_next_pc     <= '0;
      ctrl_commit      <= 1'b0;
      flush_ack_commit <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; the pulse defaults below are
      // overridden later in the same block, so each pulse is high for exactly one cycle.
      ctrl_flush_begin <= 1'b0;
      ctrl_trap        <= 1'b0;
      ctrl_mode_return <= 1'b0;
      ctrl_commit      <= 1'b0;

      case (state)
        S_RUN: begin
          if (flush_req) begin
            // A beat arriving with the flush request is swallowed without effect.
            state            <= S_FLUSH;
            flush_ack_commit <= 1'b1;
          end else if (beat_fire && beat_match) begin
            commit_token <= commit_token + TOKEN_W'(1);
            if (in_trap) begin
              ctrl_trap        <= 1'b1;
              ctrl_flush_begin <= 1'b1;
              ctrl_trap_cause  <= in_trap_cause;
              ctrl_trap_value  <= in_trap_value;
              ctrl_next_pc     <= in_pc;
              state            <= S_FLUSH;
            end else if (in_mode_return) begin
              ctrl_commit      <= 1'b1;
              ctrl_mode_return <= 1'b1;
              ctrl_flush_begin <= 1'b1;
              state            <= S_FLUSH;
            end else if (in_redirect) begin
              ctrl_commit      <= 1'b1;
              ctrl_flush_begin <= 1'b1;
              ctrl_next_pc     <= in_next_pc;
              state            <= S_FLUSH;
            end else if (in_wfi) begin
              ctrl_commit <= 1'b1;
              in_ready    <= 1'b0;
              state       <= S_WAIT;
            end else begin
              ctrl_commit <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (flush_req) begin
            state            <= S_FLUSH;
            in_ready         <= 1'b1;
            flush_ack_commit <= 1'b1;
          end else if (ctrl_begin_irq) begin
            state    <= S_FLUSH;
            in_ready <= 1'b1;
          end
        end

        S_FLUSH: begin
          // Beats are accepted and dropped until the handshake completes.
          if (flush_req) begin
            flush_ack_commit <= 1'b1;
          end else if (flush_ack_commit) begin
            flush_ack_commit <= 1'b0;
            state            <= S_RUN;
          end
        end

        default: begin
          state    <= S_RUN;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
